// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants for the round-robin mux arbiter: requester count,
// select width and the two-state controller encoding.
package mux8_rr_arbiter_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_GRANT = 1'b1;

endpackage

// File: rtl/mux8_rr_arbiter_mux.sv
// Plain 8-to-1 single-bit multiplexer; the arbiter owns its select.
module mux_8to1 (
  input  logic       A0,
  input  logic       A1,
  input  logic       A2,
  input  logic       A3,
  input  logic       A4,
  input  logic       A5,
  input  logic       A6,
  input  logic       A7,
  input  logic [2:0] sel,
  output logic       Y
);

  // select one of eight data lines
  always_comb begin
    Y = 1'b0;
    case (sel)
      3'd0:    Y = A0;
      3'd1:    Y = A1;
      3'd2:    Y = A2;
      3'd3:    Y = A3;
      3'd4:    Y = A4;
      3'd5:    Y = A5;
      3'd6:    Y = A6;
      3'd7:    Y = A7;
      default: Y = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter granting one shared 8-to-1 bit path per tenure;
// a tenure ends on request drop or after MAX_HOLD cycles.
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] din,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       dout
);

  logic             state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [7:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [SEL_W:0]   pick_s;
  logic             mux_y_s;

  // First set request scanning upward from p with wrap; MSB flags a hit.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [SEL_W-1:0]   p);
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] win;
    found = 1'b0;
    win   = p;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = p + SEL_W'(i);
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  assign pick_s = rr_pick(req, ptr_q);

  // next-state logic for the IDLE/GRANT controller
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      STATE_IDLE: begin
        if (pick_s[SEL_W]) begin
          state_d    = STATE_GRANT;
          sel_d      = pick_s[SEL_W-1:0];
          gnt_d      = 8'b1 << pick_s[SEL_W-1:0];
          busy_d     = 1'b1;
          hold_cnt_d = {CNT_W{1'b0}};
        end else begin
          state_d = STATE_IDLE;
          gnt_d   = 8'b0;
          busy_d  = 1'b0;
        end
      end
      STATE_GRANT: begin
        // the served requester drops to lowest priority
        if (!req[sel_q] || (hold_cnt_q == CNT_W'(MAX_HOLD - 1))) begin
          state_d = STATE_IDLE;
          gnt_d   = 8'b0;
          busy_d  = 1'b0;
          ptr_d   = sel_q + 3'd1;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STATE_IDLE;
        gnt_d   = 8'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // controller registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= STATE_IDLE;
      ptr_q      <= 3'd0;
      sel_q      <= 3'd0;
      gnt_q      <= 8'b0;
      busy_q     <= 1'b0;
      hold_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  mux_8to1 u_mux (
    .A0  (din[0]),
    .A1  (din[1]),
    .A2  (din[2]),
    .A3  (din[3]),
    .A4  (din[4]),
    .A5  (din[5]),
    .A6  (din[6]),
    .A7  (din[7]),
    .sel (sel_q),
    .Y   (mux_y_s)
  );

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  assign dout = mux_y_s & busy_q;

endmodule
